// File: rtl/hub75_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : hub75_rx_if
// Brief    : Pixel-word valid/ready stream carried out of the HUB75 receiver.
// Revision : 1.0
// ============================================================================
interface hub75_rx_if;
   logic       pix_valid;
   logic       pix_ready;
   logic [5:0] pix_x;
   logic [4:0] pix_row;
   logic [2:0] pix_rgb0;
   logic [2:0] pix_rgb1;
   logic       pix_last;

   modport master (
      output pix_valid, pix_x, pix_row, pix_rgb0, pix_rgb1, pix_last,
      input  pix_ready
   );

   modport slave (
      input  pix_valid, pix_x, pix_row, pix_rgb0, pix_rgb1, pix_last,
      output pix_ready
   );
endinterface
`default_nettype wire

// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : hub75_rx
// Brief    : HUB75 1-bit-RGB panel receiver: rebuilds the 64-column shift
//            register, captures rows on data latches and streams them out.
//            Define HUB75_RX_FM6126_EN to decode FM6126 REG1/REG2 writes.
// Revision : 1.0
// ============================================================================
module hub75_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  wire logic        clk,
   input  wire logic        resetn,
   input  wire logic [15:0] panel_in,
   hub75_rx_if.master       pix,
   output logic             overrun,
   output logic             bad_len,
   output logic             fm_reg_valid,
   output logic             fm_reg_sel,
   output logic [15:0]      fm_reg_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   logic [15:0]      sync_q [SYNC_STAGES];
   logic [15:0]      pins_s;
   logic             sclk_q, latch_q, blank_q;
   logic             sclk_rise, latch_fall, blank_fall, data_latch;
   logic [63:0][5:0] sr_q, sr_d, row_buf_q;
   logic [6:0]       shift_cnt_q, shift_cnt_d;
   logic [3:0]       lat_cnt_q, lat_cnt_d;
   state_t           state_q;
   logic             pix_valid_q, pix_last_q;
   logic [5:0]       pix_x_q, x_inc;
   logic [4:0]       pix_row_q;
   logic [5:0]       pix_rgb_q;
   logic             overrun_q, bad_len_q;
   logic             unused_pins;

   assign pins_s      = sync_q[SYNC_STAGES-1];
   assign unused_pins = pins_s[3] ^ pins_s[7];
   assign sclk_rise   = pins_s[14] & ~sclk_q;
   assign latch_fall  = ~pins_s[13] & latch_q;
   assign blank_fall  = ~pins_s[12] & blank_q;
   assign x_inc       = pix_x_q + 6'd1;

   // Next-state values include an sclk edge seen in the same cycle as a
   // latch fall, so classification and the captured row both see that shift.
   always_comb begin
      sr_d        = sr_q;
      shift_cnt_d = shift_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      if (sclk_rise) begin
         sr_d = {sr_q[62:0], pins_s[6:4], pins_s[2:0]};
         if (shift_cnt_q != 7'd127) shift_cnt_d = shift_cnt_q + 7'd1;
         if ((pins_s[13] || latch_q) && (lat_cnt_q != 4'd15)) lat_cnt_d = lat_cnt_q + 4'd1;
      end
   end

   assign data_latch = latch_fall && (lat_cnt_d == 4'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         sclk_q  <= 1'b0;
         latch_q <= 1'b0;
         blank_q <= 1'b0;
      end else begin
         sync_q[0] <= panel_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         sclk_q  <= pins_s[14];
         latch_q <= pins_s[13];
         blank_q <= pins_s[12];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sr_q        <= '0;
         shift_cnt_q <= '0;
         lat_cnt_q   <= '0;
         bad_len_q   <= 1'b0;
      end else begin
         sr_q <= sr_d;
         if (latch_fall) begin
            shift_cnt_q <= '0;
            lat_cnt_q   <= '0;
         end else begin
            shift_cnt_q <= shift_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
         end
         if (data_latch && (shift_cnt_d != 7'd64)) bad_len_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         row_buf_q   <= '0;
         pix_valid_q <= 1'b0;
         pix_last_q  <= 1'b0;
         pix_x_q     <= '0;
         pix_row_q   <= '0;
         pix_rgb_q   <= '0;
         overrun_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (data_latch) begin
                  row_buf_q <= sr_d;
                  state_q   <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (data_latch) row_buf_q <= sr_d;
               if (blank_fall) begin
                  state_q     <= S_STREAM;
                  pix_valid_q <= 1'b1;
                  pix_x_q     <= '0;
                  pix_last_q  <= 1'b0;
                  pix_row_q   <= {pins_s[15], pins_s[11:8]};
                  pix_rgb_q   <= data_latch ? sr_d[63] : row_buf_q[63];
               end
            end
            S_STREAM: begin
               if (data_latch) overrun_q <= 1'b1;
               if (pix.pix_ready) begin
                  if (pix_last_q) begin
                     state_q     <= S_IDLE;
                     pix_valid_q <= 1'b0;
                     pix_last_q  <= 1'b0;
                     pix_x_q     <= '0;
                     pix_rgb_q   <= '0;
                  end else begin
                     // Column x sits at row_buf[63-x]; ~x is 63-x in 6 bits.
                     pix_x_q    <= x_inc;
                     pix_last_q <= (x_inc == 6'd63);
                     pix_rgb_q  <= row_buf_q[~x_inc];
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pix.pix_valid = pix_valid_q;
   assign pix.pix_x     = pix_x_q;
   assign pix.pix_row   = pix_row_q;
   assign pix.pix_rgb1  = pix_rgb_q[5:3];
   assign pix.pix_rgb0  = pix_rgb_q[2:0];
   assign pix.pix_last  = pix_last_q;
   assign overrun       = overrun_q;
   assign bad_len       = bad_len_q;

`ifdef HUB75_RX_FM6126_EN
   logic        fm_valid_q, fm_sel_q;
   logic [15:0] fm_data_q, fm_data_d;
   logic        fm_write;

   assign fm_write = latch_fall && ((lat_cnt_d == 4'd11) || (lat_cnt_d == 4'd12));

   always_comb begin
      fm_data_d = '0;
      for (int i = 0; i < 16; i++) fm_data_d[i] = sr_d[i][0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fm_valid_q <= 1'b0;
         fm_sel_q   <= 1'b0;
         fm_data_q  <= '0;
      end else begin
         fm_valid_q <= fm_write;
         if (fm_write) begin
            fm_sel_q  <= (lat_cnt_d == 4'd12);
            fm_data_q <= fm_data_d;
         end
      end
   end

   assign fm_reg_valid = fm_valid_q;
   assign fm_reg_sel   = fm_sel_q;
   assign fm_reg_data  = fm_data_q;
`else
   assign fm_reg_valid = 1'b0;
   assign fm_reg_sel   = 1'b0;
   assign fm_reg_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_rx
// Brief    : Directed bench for hub75_rx with a pixel-history model and a
//            per-cycle stream/FM-write monitor.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_hub75_rx;

   typedef struct packed {
      logic [5:0] x;
      logic [4:0] row;
      logic [2:0] r1;
      logic [2:0] r0;
      logic       last;
   } word_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [2:0]  p_rgb0 = '0, p_rgb1 = '0;
   logic [4:0]  p_addr = '0;
   logic        p_blank = 1'b1, p_latch = 1'b0, p_sclk = 1'b0;
   logic [15:0] panel_in;
   logic        overrun, bad_len, fm_reg_valid, fm_reg_sel;
   logic [15:0] fm_reg_data;

   hub75_rx_if bus();

   assign panel_in = {p_addr[4], p_sclk, p_latch, p_blank, p_addr[3:0], 1'b0, p_rgb1, 1'b0, p_rgb0};

   hub75_rx #(.SYNC_STAGES(2)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .panel_in     (panel_in),
      .pix          (bus),
      .overrun      (overrun),
      .bad_len      (bad_len),
      .fm_reg_valid (fm_reg_valid),
      .fm_reg_sel   (fm_reg_sel),
      .fm_reg_data  (fm_reg_data)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   word_t       sb[$];
   logic [16:0] fmq[$];
   logic [5:0]  hist[$];
   logic [5:0]  m_row [64];
   bit          m_armed = 0, exp_overrun = 0, exp_bad_len = 0;
   int          m_shifts = 0, m_lat_edges = 0;
   int          xfers = 0, fm_seen = 0, ready_mode = 0;
   logic [5:0]  log_rgb [64];
   logic [4:0]  log_row = '0;
   logic [16:0] last_fm = '0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [5:0] pix_of(input int pattern, input int x);
      logic [5:0] v;
      v = x[5:0];
      case (pattern)
         0:       return {v[2:0], ~v[2:0]};
         1:       return v ^ 6'h2A;
         default: return ~v;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      sb.delete();
      fmq.delete();
      hist.delete();
      repeat (64) hist.push_back(6'd0);
      m_armed = 0; m_shifts = 0; m_lat_edges = 0;
      exp_overrun = 0; exp_bad_len = 0;
   endtask

   // Spec rules on a latch fall, applied to the bench's own pixel history.
   task automatic model_latch_fall();
      logic [15:0] d;
      d = '0;
      if (m_lat_edges == 0) begin
         if (m_shifts != 64) exp_bad_len = 1;
         if (sb.size() != 0) exp_overrun = 1;
         else begin
            for (int x = 0; x < 64; x++) m_row[x] = hist[hist.size() - 64 + x];
            m_armed = 1;
         end
      end
`ifdef HUB75_RX_FM6126_EN
      else if (m_lat_edges == 11 || m_lat_edges == 12) begin
         for (int i = 0; i < 16; i++) d[i] = hist[hist.size() - 1 - i][0];
         fmq.push_back({m_lat_edges == 12, d});
      end
`endif
      m_shifts = 0;
      m_lat_edges = 0;
   endtask

   task automatic shift_pix(input logic [5:0] p, input bit lat);
      p_sclk = 0; p_rgb1 = p[5:3]; p_rgb0 = p[2:0]; p_latch = lat;
      tick(3);
      p_sclk = 1;
      hist.push_back(p);
      m_shifts++;
      if (lat) m_lat_edges++;
      tick(3);
      p_sclk = 0;
   endtask

   task automatic drop_latch();
      p_sclk = 0;
      tick(3);
      p_latch = 0;
      model_latch_fall();
      tick(3);
   endtask

   task automatic data_latch();
      p_sclk = 0;
      p_latch = 1;
      tick(3);
      drop_latch();
   endtask

   task automatic shift_row(input int pattern, input int n);
      for (int x = 0; x < n; x++) shift_pix(pix_of(pattern, x), 0);
   endtask

   task automatic unblank(input logic [4:0] a);
      word_t w;
      p_addr = a;
      tick(3);
      p_blank = 0;
      if (m_armed) begin
         for (int x = 0; x < 64; x++) begin
            w.x = x[5:0]; w.row = a; w.r1 = m_row[x][5:3]; w.r0 = m_row[x][2:0];
            w.last = (x == 63);
            sb.push_back(w);
         end
         m_armed = 0;
      end
      tick(3);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000 && sb.size() != 0; i++) tick(1);
      check({name, "_drain"}, sb.size(), 0);
      tick(10);
      check({name, "_bad_len"}, {31'd0, bad_len}, {31'd0, exp_bad_len});
      check({name, "_overrun"}, {31'd0, overrun}, {31'd0, exp_overrun});
      p_blank = 1;
      tick(3);
   endtask

   task automatic fm_seq(input logic [15:0] val, input int nlat);
      logic b;
      for (int k = 0; k < 64; k++) begin
         b = (k >= 48) ? val[63 - k] : 1'b0;
         shift_pix({5'd0, b}, k >= 64 - nlat);
      end
      drop_latch();
      tick(10);
   endtask

   // Ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = held low.
   initial begin
      bus.pix_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       bus.pix_ready = 1'b1;
            1:       bus.pix_ready = ~bus.pix_ready;
            default: bus.pix_ready = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      word_t got, prev, exp;
      bit    stalled;
      stalled = 0;
      prev = '0;
      forever begin
         @(negedge clk); #1;
         got = {bus.pix_x, bus.pix_row, bus.pix_rgb1, bus.pix_rgb0, bus.pix_last};
         if (!resetn) stalled = 0;
         else begin
            if (stalled) check("stall_hold", {13'd0, bus.pix_valid, got}, {13'd0, 1'b1, prev});
            if (bus.pix_valid && bus.pix_ready) begin
               if (sb.size() == 0) check("unexpected_word", {14'd0, got}, 32'hFFFF_FFFF);
               else begin
                  exp = sb.pop_front();
                  check("word", {14'd0, got}, {14'd0, exp});
               end
               log_rgb[bus.pix_x] = {bus.pix_rgb1, bus.pix_rgb0};
               log_row = bus.pix_row;
               xfers++;
            end
            stalled = bus.pix_valid && !bus.pix_ready;
            prev = got;
            if (fm_reg_valid) begin
               fm_seen++;
               last_fm = {fm_reg_sel, fm_reg_data};
               if (fmq.size() == 0) check("fm_unexpected", {15'd0, last_fm}, 32'hFFFF_FFFF);
               else check("fm_write", {15'd0, last_fm}, {15'd0, fmq.pop_front()});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int  xf0;
      bit  hit;
      model_reset();
      tick(3);
      check("rst_valid",   {31'd0, bus.pix_valid}, 0);
      check("rst_flags",   {29'd0, overrun, bad_len, fm_reg_valid}, 0);
      check("rst_outputs", {8'd0, bus.pix_x, bus.pix_row, bus.pix_rgb1, bus.pix_rgb0, bus.pix_last}, 0);
      resetn = 1;
      tick(5);

      // Full row at full rate
      ready_mode = 0;
      xf0 = xfers;
      shift_row(0, 64);
      data_latch();
      unblank(5'd5);
      drain("full_row");
      check("full_row_count", xfers - xf0, 64);
      check("full_row_x0",  {26'd0, log_rgb[0]},  {26'd0, 6'b000111});
      check("full_row_x5",  {26'd0, log_rgb[5]},  {26'd0, 6'b101010});
      check("full_row_x63", {26'd0, log_rgb[63]}, {26'd0, 6'b111000});
      check("full_row_row", {27'd0, log_row}, 5);

      // Backpressure
      ready_mode = 1;
      xf0 = xfers;
      shift_row(1, 64);
      data_latch();
      unblank(5'd22);
      drain("backpressure");
      check("backpressure_count", xfers - xf0, 64);
      check("backpressure_row", {27'd0, log_row}, 22);
      ready_mode = 0;

      // FM6126 register writes
      xf0 = xfers;
      fm_seq(16'h7FFF, 11);
      unblank(5'd3);
      drain("fm_reg1");
`ifdef HUB75_RX_FM6126_EN
      check("fm_reg1_value", {15'd0, last_fm}, {15'd0, 1'b0, 16'h7FFF});
`endif
      fm_seq(16'h0040, 12);
      unblank(5'd3);
      drain("fm_reg2");
      check("fm_nostream", xfers - xf0, 0);
      check("fm_pending", fmq.size(), 0);
`ifdef HUB75_RX_FM6126_EN
      check("fm_reg2_value", {15'd0, last_fm}, {15'd0, 1'b1, 16'h0040});
      check("fm_count", fm_seen, 2);
`else
      check("fm_count", fm_seen, 0);
`endif

      // Short row
      xf0 = xfers;
      shift_row(2, 63);
      data_latch();
      unblank(5'd12);
      drain("short_row");
      check("short_row_count", xfers - xf0, 64);
      check("short_row_flag", {31'd0, bad_len}, 1);

      // Second latch while armed replaces the row
      xf0 = xfers;
      shift_row(0, 64);
      data_latch();
      shift_row(1, 64);
      data_latch();
      unblank(5'd30);
      drain("armed_replace");
      check("armed_replace_count", xfers - xf0, 64);
      check("armed_replace_x0", {26'd0, log_rgb[0]}, {26'd0, 6'h2A});
      check("armed_replace_ovr", {31'd0, overrun}, 0);

      // Overrun: second row latched while the first is stalled
      ready_mode = 2;
      xf0 = xfers;
      shift_row(2, 64);
      data_latch();
      unblank(5'd7);
      tick(10);
      shift_row(0, 64);
      data_latch();
      tick(10);
      check("overrun_flag", {31'd0, overrun}, 1);
      ready_mode = 0;
      drain("overrun");
      check("overrun_count", xfers - xf0, 64);
      check("overrun_x0", {26'd0, log_rgb[0]}, {26'd0, 6'h3F});

      // Mid-stream reset at column 30
      shift_row(1, 64);
      data_latch();
      unblank(5'd1);
      hit = 0;
      for (int i = 0; i < 500 && !hit; i++) begin
         @(negedge clk);
         if (bus.pix_valid && bus.pix_x == 6'd30) hit = 1;
      end
      check("reset_reach_x30", {31'd0, hit}, 1);
      resetn = 0;
      #1;
      check("reset_valid",   {31'd0, bus.pix_valid}, 0);
      check("reset_overrun", {31'd0, overrun}, 0);
      check("reset_bad_len", {31'd0, bad_len}, 0);
      check("reset_fm",      {31'd0, fm_reg_valid}, 0);
      model_reset();
      tick(3);
      p_blank = 1;
      tick(2);
      resetn = 1;
      tick(5);
      xf0 = xfers;
      shift_row(2, 64);
      data_latch();
      unblank(5'd4);
      drain("after_reset");
      check("after_reset_count", xfers - xf0, 64);
      check("after_reset_row", {27'd0, log_row}, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
